// File: rtl/mux_arb_n_if.sv
// Handshake bundle between N producers and one consumer of the arbitrating mux.
// master drives requests and consumer ready; slave is the mux itself.
interface mux_arb_n_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int CW    = $clog2(N)
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               flush;
  logic [WIDTH-1:0]   out_data;
  logic [CW-1:0]      out_ch;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel arbitrating mux (fixed priority or round-robin) into a 2-entry skid buffer.
// Latency: 1 clock from accept edge to out_valid when the buffer is empty.
// Backpressure: in_ready depends only on buffer occupancy and flush, never on out_ready.
module mux_arb_n_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            push;
  logic            pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push_rdy = (count < CNTW'(DEPTH));
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;

  // Storage is reset too so the head reads zero after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int CW    = $clog2(N)
) (
  input  logic       clk,
  input  logic       rstn,
  mux_arb_n_if.slave bus
);
  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic [CW-1:0]    ch;
  } entry_t;

  logic [N-1:0]  grant;
  logic [CW-1:0] gidx;
  logic          gany;
  logic [CW-1:0] rr_ptr;
  logic          space;
  logic          buf_rdy;
  logic          push;
  entry_t        push_ent;
  entry_t        head_ent;

  // Search order starts at rr_ptr in round-robin mode, at 0 otherwise.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    gidx  = '0;
    gany  = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (MODE == 1) ? ((int'(rr_ptr) + k) % N) : k;
      if (!gany && bus.in_valid[idx]) begin
        gany = 1'b1;
        gidx = CW'(idx);
      end
    end
    if (gany) grant[gidx] = 1'b1;
  end

  assign space        = buf_rdy && !bus.flush && rstn;
  assign bus.in_ready = grant & {N{space}};
  assign push         = |(bus.in_valid & bus.in_ready);

  assign push_ent.dat = bus.in_data[int'(gidx) * WIDTH +: WIDTH];
  assign push_ent.ch  = gidx;

  mux_arb_n_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (2)
  ) u_buf (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (bus.flush),
    .push_vld (push),
    .push_rdy (buf_rdy),
    .push_dat (push_ent),
    .pop_vld  (bus.out_valid),
    .pop_rdy  (bus.out_ready),
    .pop_dat  (head_ent)
  );

  assign bus.out_data = head_ent.dat;
  assign bus.out_ch   = head_ent.ch;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (MODE == 1 && push) begin
      rr_ptr <= (gidx == CW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: fixed-priority and round-robin instances, scoreboard-checked outputs.
module tb_mux_arb_n;
  logic clk;
  logic rstn;

  mux_arb_n_if #(.WIDTH(32), .N(4)) i0 ();
  mux_arb_n_if #(.WIDTH(32), .N(4)) i1 ();

  mux_arb_n #(.WIDTH(32), .N(4), .MODE(0)) u_fp (.clk(clk), .rstn(rstn), .bus(i0));
  mux_arb_n #(.WIDTH(32), .N(4), .MODE(1)) u_rr (.clk(clk), .rstn(rstn), .bus(i1));

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  ch;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int vectors = 0;
  int miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [1:0] c);
    exp_t e;
    e.dat = d;
    e.ch  = c;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitors: every handshake pops the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && i0.out_valid && i0.out_ready && !i0.flush) begin
        if (q0.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL m0_extra: got ch%0d data 0x%0h, expected no output", i0.out_ch, i0.out_data);
        end else begin
          e = q0.pop_front();
          check("m0_data", i0.out_data, e.dat);
          check("m0_ch", i0.out_ch, e.ch);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && i1.out_valid && i1.out_ready && !i1.flush) begin
        if (q1.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL m1_extra: got ch%0d data 0x%0h, expected no output", i1.out_ch, i1.out_data);
        end else begin
          e = q1.pop_front();
          check("m1_data", i1.out_data, e.dat);
          check("m1_ch", i1.out_ch, e.ch);
        end
      end
    end
  end

  initial begin
    rstn         = 1'b0;
    i0.in_valid  = 4'hF;
    i1.in_valid  = 4'hF;
    i0.in_data   = '0;
    i1.in_data   = '0;
    i0.flush     = 1'b0;
    i1.flush     = 1'b0;
    i0.out_ready = 1'b0;
    i1.out_ready = 1'b0;
    #3;
    check("rst_in_ready0", i0.in_ready, 4'b0000);
    check("rst_in_ready1", i1.in_ready, 4'b0000);
    check("rst_out_valid0", i0.out_valid, 1'b0);
    check("rst_out_valid1", i1.out_valid, 1'b0);
    check("rst_out_data0", i0.out_data, 32'h0);
    check("rst_out_ch1", i1.out_ch, 2'd0);
    tick();
    tick();
    i0.in_valid = 4'h0;
    i1.in_valid = 4'h0;
    #2 rstn = 1'b1;
    tick();
    tick();
    check("idle_out_valid0", i0.out_valid, 1'b0);
    check("idle_out_valid1", i1.out_valid, 1'b0);

    // Fixed priority: ch1 beats ch3 every cycle.
    i0.in_data   = {32'h33, 32'h0, 32'h11, 32'h0};
    i0.out_ready = 1'b1;
    i0.in_valid  = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("fp_in_ready", i0.in_ready, 4'b0010);
      q0.push_back(mk(32'h11, 2'd1));
      tick();
    end
    i0.in_valid = 4'h0;
    repeat (3) tick();
    check("fp_drained", i0.out_valid, 1'b0);

    // Round-robin across all four channels, pointer wraps 3 -> 0.
    i1.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    i1.out_ready = 1'b1;
    i1.in_valid  = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_in_ready", i1.in_ready, 64'(1) << (k % 4));
      q1.push_back(mk(32'hA0 + 32'(k % 4), 2'(k % 4)));
      tick();
    end
    i1.in_valid = 4'h0;
    repeat (3) tick();
    check("rr_drained", i1.out_valid, 1'b0);

    // Backpressure: two accepts fill the skid buffer, then release.
    i0.out_ready = 1'b0;
    i0.in_valid  = 4'b0001;
    i0.in_data[31:0] = 32'h50;
    #1;
    check("bp_acc0", i0.in_ready, 4'b0001);
    q0.push_back(mk(32'h50, 2'd0));
    tick();
    i0.in_data[31:0] = 32'h51;
    #1;
    check("bp_acc1", i0.in_ready, 4'b0001);
    q0.push_back(mk(32'h51, 2'd0));
    tick();
    i0.in_data[31:0] = 32'h52;
    #1;
    check("bp_full_rdy", i0.in_ready, 4'b0000);
    check("bp_head", i0.out_data, 32'h50);
    tick();
    check("bp_full_rdy2", i0.in_ready, 4'b0000);
    check("bp_hold", i0.out_data, 32'h50);
    check("bp_valid", i0.out_valid, 1'b1);
    i0.out_ready = 1'b1;
    #1;
    check("bp_pop_only", i0.in_ready, 4'b0000);
    tick();
    check("bp_resume", i0.in_ready, 4'b0001);
    q0.push_back(mk(32'h52, 2'd0));
    tick();
    i0.in_data[31:0] = 32'h53;
    #1;
    check("bp_stream", i0.in_ready, 4'b0001);
    q0.push_back(mk(32'h53, 2'd0));
    tick();
    i0.in_valid = 4'h0;
    repeat (3) tick();
    check("bp_drained", i0.out_valid, 1'b0);

    // Flush with a full buffer; round-robin pointer (2) must survive.
    i1.out_ready = 1'b0;
    i1.in_valid  = 4'b0100;
    #1;
    check("fl_fill0", i1.in_ready, 4'b0100);
    q1.push_back(mk(32'hA2, 2'd2));
    tick();
    check("fl_fill1", i1.in_ready, 4'b0100);
    q1.push_back(mk(32'hA2, 2'd2));
    tick();
    i1.in_valid  = 4'hF;
    i1.flush     = 1'b1;
    i1.out_ready = 1'b1;
    #1;
    check("fl_in_ready", i1.in_ready, 4'b0000);
    q1.delete();
    tick();
    i1.flush = 1'b0;
    #1;
    check("fl_out_valid", i1.out_valid, 1'b0);
    check("fl_next_grant", i1.in_ready, 4'b1000);
    q1.push_back(mk(32'hA3, 2'd3));
    tick();
    i1.in_valid = 4'h0;
    repeat (3) tick();

    // Asynchronous reset with one entry held; pointer left at 3 beforehand.
    i1.out_ready = 1'b0;
    i1.in_valid  = 4'b0100;
    #1;
    check("ar_grant", i1.in_ready, 4'b0100);
    q1.push_back(mk(32'hA2, 2'd2));
    tick();
    i1.in_valid = 4'h0;
    check("ar_count1", i1.out_valid, 1'b1);
    #1 rstn = 1'b0;
    #1;
    check("ar_async_valid", i1.out_valid, 1'b0);
    check("ar_async_data", i1.out_data, 32'h0);
    q1.delete();
    #2 rstn = 1'b1;
    i1.in_valid  = 4'hF;
    i1.out_ready = 1'b1;
    #1;
    check("ar_first_grant", i1.in_ready, 4'b0001);
    q1.push_back(mk(32'hA0, 2'd0));
    tick();
    i1.in_valid = 4'h0;
    repeat (3) tick();

    check("q0_empty", 64'(q0.size()), 64'd0);
    check("q1_empty", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-channel arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Each cycle it selects one requesting channel, by fixed priority or round-robin, and writes that channel's data into a 2-entry output skid buffer.
- The buffer makes out_ready timing-isolated from all in_ready signals.
- Used in the CPU datapath wherever several producers share one consumer, for example a memory-port or write-back merge.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels, N >= 2.
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- CW, $clog2(N), channel-index width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept; at most one bit high per cycle.
- flush  input  1  synchronous clear of buffered entries.
- out_data  output  WIDTH  head-of-buffer data.
- out_ch  output  CW  source channel index of the head entry.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (rstn low, asynchronous):
  - count = 0, out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer rr_ptr = 0.
  - in_ready = 0 while rstn is low.
- Buffer:
  - 2-entry FIFO holding {data, ch}; count ranges 0..2.
  - space = (count < 2) && !flush.
  - pop = out_valid && out_ready; out_valid = (count != 0).
- Grant (combinational, from in_valid and rr_ptr only; never from out_ready):
  - MODE 0: grant the lowest i with in_valid[i].
  - MODE 1: grant the first i with in_valid[i], searching rr_ptr, rr_ptr+1, … mod N.
  - in_ready[i] = grant[i] && space.
  - push = |(in_valid & in_ready).
- Transfer:
  - Push writes the granted channel's data and index at the buffer tail.
  - Latency: the accept edge makes the entry visible on out_data/out_ch/out_valid in the next cycle (1 clock), when the buffer was empty.
- Count update:
  - push && !pop: +1.
  - pop && !push: −1.
  - push && pop: unchanged; the head advances and the new entry goes to the tail.
- Full (count = 2):
  - No push, even if pop occurs the same cycle.
  - Steady-state full throughput is therefore sustained at count = 1.
- Empty (count = 0): out_valid = 0; out_ready is ignored.
- rr_ptr (MODE 1 only):
  - On push from channel g, rr_ptr <= (g+1) mod N.
  - Wraps from N−1 to 0.
  - Unchanged when there is no push.
  - Ignored in MODE 0.
- flush:
  - While high, in_ready = 0.
  - At the next edge count <= 0 and out_valid falls; any pop in that cycle is discarded.
  - rr_ptr is preserved.
  - flush dominates push and pop.
- Ordering: entries leave in acceptance order; no reordering.
- Input stability:
  - Inputs may drop in_valid without being accepted (no request-hold requirement).
  - Once accepted, an entry is never lost except by flush or reset.
- Reset mid-operation: all entries are discarded immediately; outputs return to reset values asynchronously.
- Output stability: while out_valid && !out_ready, out_data and out_ch hold stable.

Test Plan:
- Reset/idle: rstn = 0 with in_valid = 4'b1111 → in_ready = 0, out_valid = 0, out_data = 0. After release with all in_valid = 0 → out_valid stays 0.
- Fixed priority, MODE = 0:
  - Setup: in_valid = 4'b1010, ch1 = 0x11, ch3 = 0x33, out_ready = 1 continuously.
  - Required: in_ready = 4'b0010 every cycle; out stream 0x11/ch1 repeated; ch3 starved.
- Round-robin, MODE = 1:
  - Setup: in_valid = 4'b1111, data i = 0xA0+i, out_ready = 1.
  - Required: out_ch sequence 0,1,2,3,0,1 on consecutive cycles after 1-cycle latency; rr_ptr wraps 3→0.
- Backpressure/skid:
  - Setup: out_ready = 0, one channel streaming.
  - Required: exactly 2 accepts, then in_ready = 0 with count = 2 and out_data held.
  - Then set out_ready = 1: the first pop with no push gives count = 1; afterwards one push plus one pop per cycle; no data lost or duplicated.
- Flush:
  - Setup: count = 2, assert flush for 1 cycle with in_valid high.
  - Required: in_ready = 0 that cycle; next cycle out_valid = 0 and count = 0; rr_ptr unchanged; the next grant follows the prior pointer.
- Async reset mid-stream:
  - Setup: drop rstn between edges with count = 1.
  - Required: out_valid goes 0 without a clock edge. After release, the first grant under MODE 1 is channel 0.
